// File: rtl/chip8_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : chip8_rom_loader
// Purpose  : Feeds a Chip-8 program byte stream into the CPU memory upload
//            port. Optionally zero-fills LOAD_BASE..0xFFF, then writes the
//            streamed bytes from LOAD_BASE upward. After the last byte it
//            keeps the port for TAIL_CYCLES, releases it, pulses done and
//            holds cpu_reset_req for RST_HOLD cycles.
// Ports    : clk, reset_i (sync, active-high)
//            start                          - begin a load (IDLE only)
//            in_valid/in_data/in_last/in_ready - byte stream handshake
//            uploading/upload_en/upload_addr/upload_data - memory port
//            busy, done, overflow, byte_count, cpu_reset_req - status
// Revision : 1.0 - initial release
// ============================================================================
module chip8_rom_loader #(
    parameter logic [11:0] LOAD_BASE   = 12'h200,
    parameter bit          CLEAR_EN    = 1'b1,
    parameter int unsigned TAIL_CYCLES = 4,
    parameter int unsigned RST_HOLD    = 8192
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        uploading,
    output logic        upload_en,
    output logic [11:0] upload_addr,
    output logic [7:0]  upload_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] byte_count,
    output logic        cpu_reset_req
);

    localparam logic [11:0] c_last_addr = 12'hFFF;
    // A zero TAIL_CYCLES/RST_HOLD still spends one cycle in the state.
    localparam logic [31:0] c_tail_last = (TAIL_CYCLES > 0) ? 32'(TAIL_CYCLES - 1) : 32'd0;
    localparam logic [31:0] c_hold_last = (RST_HOLD > 0) ? 32'(RST_HOLD - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_DISCARD = 3'd3,
        S_TAIL    = 3'd4,
        S_RSTREQ  = 3'd5
    } state_t;

    state_t      r_state,         w_state_nxt;
    logic [11:0] r_ptr,           w_ptr_nxt;
    logic [11:0] r_byte_count,    w_byte_count_nxt;
    logic        r_overflow,      w_overflow_nxt;
    logic [31:0] r_cnt,           w_cnt_nxt;
    logic        r_uploading,     w_uploading_nxt;
    logic        r_upload_en,     w_upload_en_nxt;
    logic [11:0] r_upload_addr,   w_upload_addr_nxt;
    logic [7:0]  r_upload_data,   w_upload_data_nxt;
    logic        r_done,          w_done_nxt;
    logic        r_cpu_reset_req, w_cpu_reset_req_nxt;
    logic        w_accept;

    assign in_ready = (r_state == S_LOAD) || (r_state == S_DISCARD);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state         <= S_IDLE;
            r_ptr           <= 12'h000;
            r_byte_count    <= 12'h000;
            r_overflow      <= 1'b0;
            r_cnt           <= 32'd0;
            r_uploading     <= 1'b0;
            r_upload_en     <= 1'b0;
            r_upload_addr   <= 12'h000;
            r_upload_data   <= 8'h00;
            r_done          <= 1'b0;
            r_cpu_reset_req <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_byte_count    <= w_byte_count_nxt;
            r_overflow      <= w_overflow_nxt;
            r_cnt           <= w_cnt_nxt;
            r_uploading     <= w_uploading_nxt;
            r_upload_en     <= w_upload_en_nxt;
            r_upload_addr   <= w_upload_addr_nxt;
            r_upload_data   <= w_upload_data_nxt;
            r_done          <= w_done_nxt;
            r_cpu_reset_req <= w_cpu_reset_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_ptr_nxt           = r_ptr;
        w_byte_count_nxt    = r_byte_count;
        w_overflow_nxt      = r_overflow;
        w_cnt_nxt           = r_cnt;
        w_uploading_nxt     = r_uploading;
        w_upload_en_nxt     = 1'b0;
        w_upload_addr_nxt   = r_upload_addr;
        w_upload_data_nxt   = r_upload_data;
        w_done_nxt          = 1'b0;
        w_cpu_reset_req_nxt = r_cpu_reset_req;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_byte_count_nxt = 12'h000;
                    w_overflow_nxt   = 1'b0;
                    w_cnt_nxt        = 32'd0;
                    w_uploading_nxt  = 1'b1;
                    if (CLEAR_EN) begin
                        // The first zero write is issued from here so that it
                        // lands on the port together with the rise of uploading.
                        w_upload_en_nxt   = 1'b1;
                        w_upload_addr_nxt = LOAD_BASE;
                        w_upload_data_nxt = 8'h00;
                        if (LOAD_BASE == c_last_addr) begin
                            w_state_nxt = S_LOAD;
                            w_ptr_nxt   = LOAD_BASE;
                        end else begin
                            w_state_nxt = S_CLEAR;
                            w_ptr_nxt   = LOAD_BASE + 12'd1;
                        end
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_ptr_nxt   = LOAD_BASE;
                    end
                end
            end

            S_CLEAR: begin
                w_upload_en_nxt   = 1'b1;
                w_upload_addr_nxt = r_ptr;
                w_upload_data_nxt = 8'h00;
                // Stop at the top of memory instead of wrapping into 0x000.
                if (r_ptr == c_last_addr) begin
                    w_state_nxt = S_LOAD;
                    w_ptr_nxt   = LOAD_BASE;
                end else begin
                    w_ptr_nxt = r_ptr + 12'd1;
                end
            end

            S_LOAD: begin
                if (w_accept) begin
                    w_upload_en_nxt   = 1'b1;
                    w_upload_addr_nxt = r_ptr;
                    w_upload_data_nxt = in_data;
                    w_ptr_nxt         = r_ptr + 12'd1;
                    w_byte_count_nxt  = r_byte_count + 12'd1;
                    if (in_last) begin
                        w_state_nxt = S_TAIL;
                        w_cnt_nxt   = 32'd0;
                    end else if (r_ptr == c_last_addr) begin
                        // More bytes follow but memory is full: drain them.
                        w_state_nxt    = S_DISCARD;
                        w_overflow_nxt = 1'b1;
                    end
                end
            end

            S_DISCARD: begin
                w_overflow_nxt = 1'b1;
                if (w_accept && in_last) begin
                    w_state_nxt = S_TAIL;
                    w_cnt_nxt   = 32'd0;
                end
            end

            S_TAIL: begin
                if (r_cnt == c_tail_last) begin
                    w_uploading_nxt     = 1'b0;
                    w_done_nxt          = 1'b1;
                    w_cpu_reset_req_nxt = 1'b1;
                    w_cnt_nxt           = 32'd0;
                    w_state_nxt         = S_RSTREQ;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end

            S_RSTREQ: begin
                if (r_cnt == c_hold_last) begin
                    w_cpu_reset_req_nxt = 1'b0;
                    w_cnt_nxt           = 32'd0;
                    w_state_nxt         = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign uploading     = r_uploading;
    assign upload_en     = r_upload_en;
    assign upload_addr   = r_upload_addr;
    assign upload_data   = r_upload_data;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign byte_count    = r_byte_count;
    assign cpu_reset_req = r_cpu_reset_req;

endmodule
`default_nettype wire

// File: doc/chip8_rom_loader.md
# chip8_rom_loader

Upstream feeder of the Chip-8 CPU memory upload port. It accepts a byte stream of a Chip-8 program from the host-side loader (SD/serial/OSD) over a valid/ready handshake. It optionally zero-fills program space, then writes the bytes at 0x200 onward through `uploading`/`upload_en`/`upload_addr`/`upload_data`. On completion it releases the memory port and requests a CPU reset so the new program starts cleanly.

## Interface
Parameters:
- `LOAD_BASE`, 12'h200, first program address; clear and load both start here.
- `CLEAR_EN`, 1, when 1 zero-fill `LOAD_BASE`..12'hFFF before loading.
- `TAIL_CYCLES`, 4, cycles `uploading` stays high after the last write.
- `RST_HOLD`, 8192, width in cycles of `cpu_reset_req`; must span at least one `cpu_clk` period.

Ports:
- `clk` in 1: single clock for all logic; the top level ties `upload_clk` to this clock.
- `reset_i` in 1: reset, synchronous and active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `in_valid` in 1: stream byte valid.
- `in_data` in 8: stream byte.
- `in_last` in 1: marks the final byte, qualified by `in_valid`.
- `in_ready` out 1: loader accepts a byte this cycle.
- `uploading` out 1: owns the CPU memory port.
- `upload_en` out 1: write strobe, one byte per cycle.
- `upload_addr` out 12: write address.
- `upload_data` out 8: write data.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when `uploading` falls.
- `overflow` out 1: sticky; the stream exceeded 12'hFFF. Cleared by `start` or reset.
- `byte_count` out 12: number of bytes actually written. Holds its value after `done`.
- `cpu_reset_req` out 1: asserted for `RST_HOLD` cycles after `done`.

## Operation
- States are IDLE, CLEAR, LOAD, DISCARD, TAIL and RSTREQ.
- IDLE: `start` clears `ptr`, `byte_count` and `overflow`. Sets `ptr`=`LOAD_BASE`, then goes to CLEAR if `CLEAR_EN`, else LOAD.
- CLEAR: write 8'h00 at `ptr` every cycle and increment `ptr`. The write at 12'hFFF moves to LOAD with `ptr`=`LOAD_BASE`; there is no wrap to 0x000. The stream is not accepted (`in_ready`=0).
- LOAD: `in_ready`=1. Each accepted byte (`in_valid`&&`in_ready`) is written at `ptr`, then `ptr`++ and `byte_count`++.
  - Accepted with `in_last` → TAIL.
  - Accepted at `ptr`=12'hFFF without `in_last` → DISCARD.
- DISCARD: `in_ready`=1, no writes, `overflow` set. The next accepted byte with `in_last` → TAIL.
- TAIL: `uploading` stays 1 and `upload_en`=0 for `TAIL_CYCLES` cycles. Then `uploading`→0, `done` pulses, and the state goes to RSTREQ.
- RSTREQ: `cpu_reset_req`=1 for `RST_HOLD` cycles, then IDLE. `start` is ignored here.
- `start` in any state other than IDLE is ignored.
- `in_valid` with no `in_last` holds LOAD/DISCARD indefinitely. There is no timeout.
- Addresses never exceed 12 bits; `ptr` arithmetic is modulo 4096 but is bounded by the rules above.
- Reset at any point: IDLE immediately, all outputs at reset values, any partial load abandoned.

## Timing
- Reset values: `in_ready`, `uploading`, `upload_en`, `busy`, `done`, `overflow` and `cpu_reset_req` are 0. `upload_addr`, `upload_data` and `byte_count` are 0.
- `upload_*` and `uploading` are registered. A write decided in cycle n appears on the port in cycle n+1.
- `uploading` rises the cycle after `start` and coincides with the first CLEAR (or LOAD) write.
- CLEAR with base 0x200 lasts 3584 cycles: strobes at 0x200..0xFFF, back-to-back.
- LOAD throughput is 1 byte/cycle, and `in_ready` is combinational from state. A byte accepted at cycle n is written at n+1.
- `uploading` falls `TAIL_CYCLES` cycles after the last write cycle. `done` pulses in the same cycle `uploading` is first 0.
- `cpu_reset_req` rises with `done` and lasts exactly `RST_HOLD` cycles.

## Test plan
- CLEAR_EN=1: start, then stream 3 bytes A2 2A 60 with last on 60. Required:
  - 3584 zero writes (0x200..0xFFF).
  - Then writes 0x200=A2, 0x201=2A, 0x202=60.
  - `byte_count`=3, `overflow`=0, `done` 4 cycles after the final write.
- CLEAR_EN=0, `in_valid` toggling every other cycle over 5 bytes. Required: writes only on accepted cycles, contiguous addresses 0x200..0x204, no gaps or duplicates.
- Stream 3600 bytes, last on the final byte. Required:
  - Writes stop at 0xFFF.
  - `byte_count`=3584 (12'hE00) and `overflow`=1.
  - Remaining 16 bytes accepted without writes, then TAIL.
- `start` pulsed during CLEAR and during RSTREQ. Required: ignored; addresses and counts unchanged.
- `reset_i` during LOAD after 10 bytes. Required: next cycle `uploading`=0, `in_ready`=0, `byte_count`=0, no `done`, no `cpu_reset_req`.
- RST_HOLD=8. Required: `cpu_reset_req` high for exactly 8 cycles starting with `done`; `busy` falls the cycle after.
